// File: rtl/def_test_array.sv
// Channel test array: per-channel invert/buffer path plus walking-one and LFSR
// pattern sequences, with registered parity and constant tie-off outputs.
module def_test_array #(
  parameter int          WIDTH     = 8,
  parameter int          SEQ_LEN   = 16,
  parameter logic [15:0] LFSR_SEED = 16'h0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             parity_out,
  output logic [WIDTH-1:0] tie_hi,
  output logic [WIDTH-1:0] tie_lo,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, WALK, LFSR, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] walk_idx;
  logic [7:0]       seq_cnt;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nxt;
  logic [IDX_W-1:0] walk_idx_nxt;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [WIDTH-1:0] idle_out(input logic [WIDTH-1:0] d,
                                                input logic [1:0] m);
    case (m)
      2'b00:   return ~d;
      2'b01:   return d;
      default: return '0;
    endcase
  endfunction

  assign tie_hi       = '1;
  assign tie_lo       = '0;
  assign lfsr_nxt     = lfsr_step(lfsr);
  assign walk_idx_nxt = walk_idx + IDX_W'(1);

  // The sequence kind is captured by the state entered on start, so later
  // mode changes cannot disturb a running sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out        <= '0;
      parity_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lfsr       <= LFSR_SEED;
      walk_idx   <= '0;
      seq_cnt    <= '0;
    end else begin
      parity_out <= ^in;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          out <= idle_out(in, mode);
          if (start && !abort && mode[1]) begin
            busy <= 1'b1;
            if (mode[0]) begin
              state   <= LFSR;
              lfsr    <= LFSR_SEED;
              seq_cnt <= 8'd1;
              out     <= LFSR_SEED[WIDTH-1:0];
            end else begin
              state    <= WALK;
              walk_idx <= '0;
              out      <= WIDTH'(1);
            end
          end
        end
        WALK: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            out      <= '0;
            walk_idx <= '0;
          end else if (walk_idx == IDX_W'(WIDTH - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            out      <= '0;
            walk_idx <= '0;
          end else begin
            walk_idx <= walk_idx_nxt;
            out      <= WIDTH'(1) << walk_idx_nxt;
          end
        end
        LFSR: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            out     <= '0;
            seq_cnt <= '0;
          end else if (seq_cnt == 8'(SEQ_LEN)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            out     <= '0;
            seq_cnt <= '0;
          end else begin
            lfsr    <= lfsr_nxt;
            seq_cnt <= seq_cnt + 8'd1;
            out     <= lfsr_nxt[WIDTH-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
          out   <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          out   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_def_test_array.sv
// Self-checking bench for def_test_array: directed scenarios followed by random
// traffic, all compared against a sequence-list reference model.
module tb_def_test_array;

  localparam int          W    = 8;
  localparam int          SL   = 16;
  localparam logic [15:0] SEED = 16'h0001;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic [1:0]   mode = 2'b00;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] out;
  logic         parity_out;
  logic [W-1:0] tie_hi;
  logic [W-1:0] tie_lo;
  logic         busy;
  logic         done;

  int n_assert = 0;
  int n_fail   = 0;

  def_test_array #(.WIDTH(W), .SEQ_LEN(SL), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .in(din), .mode(mode), .start(start), .abort(abort),
    .out(out), .parity_out(parity_out), .tie_hi(tie_hi), .tie_lo(tie_lo),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a run is a list of expected out values, followed by one
  // done cycle. phase 0 = idle, 1 = running, 2 = done pulse.
  logic [W-1:0] q[$];
  int           phase = 0;
  logic [W-1:0] e_out;
  logic         e_par, e_busy, e_done, out_chk;

  function automatic void build_run(input logic lfsr_mode);
    logic [15:0] v;
    q.delete();
    if (!lfsr_mode) begin
      for (int k = 0; k < W; k++) q.push_back(W'(1) << k);
    end else begin
      v = SEED;
      for (int k = 0; k < SL; k++) begin
        q.push_back(v[W-1:0]);
        v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      end
    end
  endfunction

  function automatic void model_step(input logic [W-1:0] i, input logic [1:0] m,
                                     input logic s, input logic a, input logic r);
    out_chk = 1'b1;
    e_done  = 1'b0;
    if (r) begin
      phase = 0; q.delete();
      e_out = '0; e_par = 1'b0; e_busy = 1'b0;
    end else begin
      e_par = ^i;
      case (phase)
        1: begin
          if (a) begin
            phase = 0; q.delete(); e_out = '0; e_busy = 1'b0;
          end else if (q.size() == 0) begin
            phase = 2; e_out = '0; e_busy = 1'b0; e_done = 1'b1;
          end else begin
            e_out = q.pop_front(); e_busy = 1'b1;
          end
        end
        2: begin
          phase = 0; e_busy = 1'b0; out_chk = 1'b0;
        end
        default: begin
          if (s && !a && m[1]) begin
            build_run(m[0]);
            e_out = q.pop_front(); e_busy = 1'b1; phase = 1;
          end else begin
            e_out  = (m == 2'b00) ? ~i : (m == 2'b01) ? i : '0;
            e_busy = 1'b0;
          end
        end
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [W-1:0] i, input logic [1:0] m,
                     input logic s, input logic a, input logic r);
    @(negedge clk);
    din = i; mode = m; start = s; abort = a; rst = r;
    @(posedge clk);
    model_step(i, m, s, a, r);
    #1;
    if (out_chk) chk("out", 16'(out), 16'(e_out));
    chk("parity_out", 16'(parity_out), 16'(e_par));
    chk("busy", 16'(busy), 16'(e_busy));
    chk("done", 16'(done), 16'(e_done));
    chk("tie_hi", 16'(tie_hi), 16'hFF);
    chk("tie_lo", 16'(tie_lo), 16'h00);
  endtask

  initial begin
    int dcnt;
    // reset
    cyc(8'h3C, 2'b11, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("reset_out", 16'(out), 16'h00);
    // invert and buffer paths
    repeat (3) cyc(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("invert_a5", 16'(out), 16'h5A);
    chk("parity_a5", 16'(parity_out), 16'h0);
    cyc(8'h07, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc(8'h6E, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("buffer_6e", 16'(out), 16'h6E);
    cyc(8'h6E, 2'b10, 1'b0, 1'b0, 1'b0);
    // walking one, full run
    cyc(8'h11, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("walk_first", 16'(out), 16'h01);
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(8'(k), 2'b10, 1'b0, 1'b0, 1'b0);
      dcnt += int'(done);
    end
    chk("walk_done_count", 16'(dcnt), 16'd1);
    // LFSR, two identical runs
    repeat (2) begin
      cyc(8'h22, 2'b11, 1'b1, 1'b0, 1'b0);
      chk("lfsr_first", 16'(out), 16'h01);
      for (int k = 0; k < SL + 2; k++) cyc(8'h22, 2'b11, 1'b0, 1'b0, 1'b0);
    end
    // abort on third walk cycle
    cyc(8'h00, 2'b10, 1'b1, 1'b0, 1'b0);
    cyc(8'h00, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("walk_third", 16'(out), 16'h04);
    cyc(8'h00, 2'b10, 1'b0, 1'b1, 1'b0);
    chk("abort_out", 16'(out), 16'h00);
    repeat (3) cyc(8'h00, 2'b10, 1'b0, 1'b0, 1'b0);
    // start and abort together in idle
    cyc(8'h00, 2'b10, 1'b1, 1'b1, 1'b0);
    chk("start_abort_busy", 16'(busy), 16'h0);
    cyc(8'h00, 2'b10, 1'b0, 1'b0, 1'b0);
    // reset mid LFSR, then replay from seed
    cyc(8'h00, 2'b11, 1'b1, 1'b0, 1'b0);
    repeat (5) cyc(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 2'b11, 1'b1, 1'b1, 1'b1);
    cyc(8'h00, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("replay_first", 16'(out), 16'h01);
    for (int k = 0; k < SL + 2; k++) cyc(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
    // mode toggle and extra start mid run
    cyc(8'h55, 2'b11, 1'b1, 1'b0, 1'b0);
    dcnt = 0;
    for (int k = 0; k < SL + 4; k++) begin
      cyc(8'h55, (k < 3) ? 2'b11 : 2'b00, (k == 6), 1'b0, 1'b0);
      dcnt += int'(done);
    end
    chk("toggle_done_count", 16'(dcnt), 16'd1);
    // random traffic
    for (int k = 0; k < 2000; k++) begin
      cyc(8'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
